fifo_sync_param: RTL and testbench

Parametrised synchronous FIFO that integrates the dual-port storage array with write/read pointer management, occupancy counting and programmable threshold flags. It replaces the bare pointer-addressed RAM in the device datapath, so upstream and downstream logic interact only through push/pop requests and status flags, never through raw pointers.

---
 rtl/fifo_pkg.sv | 22 ++
 rtl/fifo_ram_dp.sv | 39 +++
 rtl/fifo_sync_param.sv | 132 +++++++++++++
 tb/tb_fifo_sync_param.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
//==============================================================================
// Module   : fifo_pkg
// Brief    : Shared defaults and helpers for the synchronous FIFO family.
//            Downstream arbiters reuse the default sizes and depth helper.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

package fifo_pkg;

   // Default word width and address width for FIFO instances
   localparam int c_default_data_size = 10;
   localparam int c_default_addr_size = 3;

   // Number of words addressable with the given address width
   function automatic int fifo_depth(input int addr_size);
      return 1 << addr_size;
   endfunction

endpackage : fifo_pkg

`default_nettype wire

// File: rtl/fifo_ram_dp.sv
//==============================================================================
// Module   : fifo_ram_dp
// Brief    : Dual-port storage array, synchronous write port and asynchronous
//            read address. Contents are not reset.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module fifo_ram_dp
   import fifo_pkg::*;
#(
   parameter int DATA_SIZE = c_default_data_size,
   parameter int ADDR_SIZE = c_default_addr_size
) (
   input  logic                 clk,
   input  logic                 i_we,
   input  logic [ADDR_SIZE-1:0] i_waddr,
   input  logic [DATA_SIZE-1:0] i_wdata,
   input  logic [ADDR_SIZE-1:0] i_raddr,
   output logic [DATA_SIZE-1:0] o_rdata
);

   localparam int c_depth = fifo_depth(ADDR_SIZE);

   logic [DATA_SIZE-1:0] r_mem [c_depth];

   // Write port: store the word on an accepted write
   always_ff @(posedge clk) begin
      if (i_we) begin
         r_mem[i_waddr] <= i_wdata;
      end
   end

   // Read port is purely combinational so the pop can register it in one edge
   assign o_rdata = r_mem[i_raddr];

endmodule : fifo_ram_dp

`default_nettype wire

// File: rtl/fifo_sync_param.sv
//==============================================================================
// Module   : fifo_sync_param
// Brief    : Parametrised synchronous FIFO with occupancy count, full/empty
//            and programmable almost-full/almost-empty flags.
//            Optional macro FIFO_ERR_EN adds a sticky overflow/underflow
//            flag on port error_out.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module fifo_sync_param
   import fifo_pkg::*;
#(
   parameter int DATA_SIZE = c_default_data_size,
   parameter int ADDR_SIZE = c_default_addr_size
) (
   input  logic                 clk,
   input  logic                 reset_L,
   input  logic                 push,
   input  logic [DATA_SIZE-1:0] data_in,
   input  logic                 pop,
   input  logic [ADDR_SIZE:0]   th_almost_full,
   input  logic [ADDR_SIZE:0]   th_almost_empty,
   output logic [DATA_SIZE-1:0] data_out,
   output logic                 valid_out,
   output logic [ADDR_SIZE:0]   fifo_count,
`ifdef FIFO_ERR_EN
   output logic                 error_out,
`endif
   output logic                 full,
   output logic                 empty,
   output logic                 almost_full,
   output logic                 almost_empty
);

   localparam int                 c_depth     = fifo_depth(ADDR_SIZE);
   localparam logic [ADDR_SIZE:0] c_depth_cnt = c_depth[ADDR_SIZE:0];
   localparam logic [ADDR_SIZE-1:0] c_ptr_one = 1;
   localparam logic [ADDR_SIZE:0]   c_cnt_one = 1;

   logic [ADDR_SIZE-1:0] r_wr_ptr;
   logic [ADDR_SIZE-1:0] r_rd_ptr;
   logic [ADDR_SIZE:0]   r_count;
   logic [DATA_SIZE-1:0] r_data_out;
   logic                 r_valid_out;
   logic [DATA_SIZE-1:0] w_ram_rdata;
   logic                 w_push_ok;
   logic                 w_pop_ok;
   logic                 w_full;
   logic                 w_empty;

   // Status flags derive from the registered count only
   assign w_full  = (r_count == c_depth_cnt);
   assign w_empty = (r_count == '0);

   // A full FIFO still takes a push when a pop frees a slot in the same edge;
   // an empty FIFO never serves a pop, even alongside a push
   assign w_push_ok = push && (!w_full || pop);
   assign w_pop_ok  = pop && !w_empty;

   fifo_ram_dp #(
      .DATA_SIZE (DATA_SIZE),
      .ADDR_SIZE (ADDR_SIZE)
   ) u_ram (
      .clk     (clk),
      .i_we    (w_push_ok),
      .i_waddr (r_wr_ptr),
      .i_wdata (data_in),
      .i_raddr (r_rd_ptr),
      .o_rdata (w_ram_rdata)
   );

   // Pointer and occupancy tracking; pointers wrap naturally modulo depth
   always_ff @(posedge clk or negedge reset_L) begin
      if (!reset_L) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push_ok) begin
            r_wr_ptr <= r_wr_ptr + c_ptr_one;
         end
         if (w_pop_ok) begin
            r_rd_ptr <= r_rd_ptr + c_ptr_one;
         end
         case ({w_push_ok, w_pop_ok})
            2'b10:   r_count <= r_count + c_cnt_one;
            2'b01:   r_count <= r_count - c_cnt_one;
            default: r_count <= r_count;
         endcase
      end
   end

   // Read data register: capture the head word on an accepted pop, else hold
   always_ff @(posedge clk or negedge reset_L) begin
      if (!reset_L) begin
         r_data_out  <= '0;
         r_valid_out <= 1'b0;
      end else begin
         r_valid_out <= w_pop_ok;
         if (w_pop_ok) begin
            r_data_out <= w_ram_rdata;
         end
      end
   end

`ifdef FIFO_ERR_EN
   logic r_error;

   // Sticky error: any rejected push or pop latches until reset
   always_ff @(posedge clk or negedge reset_L) begin
      if (!reset_L) begin
         r_error <= 1'b0;
      end else if ((push && !w_push_ok) || (pop && !w_pop_ok)) begin
         r_error <= 1'b1;
      end
   end

   assign error_out = r_error;
`endif

   assign data_out     = r_data_out;
   assign valid_out    = r_valid_out;
   assign fifo_count   = r_count;
   assign full         = w_full;
   assign empty        = w_empty;
   assign almost_full  = (r_count >= th_almost_full);
   assign almost_empty = (r_count <= th_almost_empty);

endmodule : fifo_sync_param

`default_nettype wire

// File: tb/tb_fifo_sync_param.sv
//==============================================================================
// Module   : tb_fifo_sync_param
// Brief    : Self-checking bench for fifo_sync_param (DATA_SIZE=10,
//            ADDR_SIZE=3). Error flag checks are active when FIFO_ERR_EN is
//            defined.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_fifo_sync_param;

   logic       clk;
   logic       reset_L;
   logic       push;
   logic [9:0] data_in;
   logic       pop;
   logic [3:0] th_almost_full;
   logic [3:0] th_almost_empty;
   logic [9:0] data_out;
   logic       valid_out;
   logic [3:0] fifo_count;
   logic       full;
   logic       empty;
   logic       almost_full;
   logic       almost_empty;
`ifdef FIFO_ERR_EN
   logic       error_out;
`endif

   int n_checks = 0;
   int n_fail   = 0;

   fifo_sync_param #(
      .DATA_SIZE (10),
      .ADDR_SIZE (3)
   ) dut (
      .clk             (clk),
      .reset_L         (reset_L),
      .push            (push),
      .data_in         (data_in),
      .pop             (pop),
      .th_almost_full  (th_almost_full),
      .th_almost_empty (th_almost_empty),
      .data_out        (data_out),
      .valid_out       (valid_out),
      .fifo_count      (fifo_count),
`ifdef FIFO_ERR_EN
      .error_out       (error_out),
`endif
      .full            (full),
      .empty           (empty),
      .almost_full     (almost_full),
      .almost_empty    (almost_empty)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Watchdog so the run always ends
   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // One clock: drive on the falling edge, sample 1 time unit after rising edge
   task automatic cycle(input logic p, input logic q, input logic [9:0] d);
      @(negedge clk);
      push    = p;
      pop     = q;
      data_in = d;
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      cycle(1'b0, 1'b0, 10'h000);
   endtask

   // Asynchronous reset pulse applied away from any clock edge
   task automatic do_reset();
      @(negedge clk);
      push    = 1'b0;
      pop     = 1'b0;
      #2;
      reset_L = 1'b0;
      #4;
      @(negedge clk);
      reset_L = 1'b1;
   endtask

   typedef struct {
      logic       push;
      logic       pop;
      logic [9:0] din;
      int         cnt;
      logic       full;
      logic       empty;
      logic       af;
      logic       ae;
      logic       valid;
      logic [9:0] dout;
      logic       err;
   } vec_t;

   vec_t vecs [18];

   function automatic vec_t mkv(input logic p, input logic q, input logic [9:0] d,
                                input int c, input logic f, input logic e,
                                input logic af, input logic ae, input logic v,
                                input logic [9:0] o, input logic er);
      vec_t t;
      t.push = p; t.pop = q; t.din = d; t.cnt = c; t.full = f; t.empty = e;
      t.af = af; t.ae = ae; t.valid = v; t.dout = o; t.err = er;
      return t;
   endfunction

   logic [9:0] q_model [$];
   logic [9:0] last_dout;
   logic       wp, wq, push_ok, pop_ok;

   initial begin
      push            = 1'b0;
      pop             = 1'b0;
      data_in         = '0;
      th_almost_full  = 4'd0;
      th_almost_empty = 4'd2;
      reset_L         = 1'b1;

      // th_almost_full = 6, th_almost_empty = 2 throughout the table
      vecs[0]  = mkv(1, 0, 10'h001, 1, 0, 0, 0, 1, 0, 10'h000, 0);
      vecs[1]  = mkv(1, 0, 10'h002, 2, 0, 0, 0, 1, 0, 10'h000, 0);
      vecs[2]  = mkv(1, 0, 10'h003, 3, 0, 0, 0, 0, 0, 10'h000, 0);
      vecs[3]  = mkv(1, 0, 10'h004, 4, 0, 0, 0, 0, 0, 10'h000, 0);
      vecs[4]  = mkv(1, 0, 10'h005, 5, 0, 0, 0, 0, 0, 10'h000, 0);
      vecs[5]  = mkv(1, 0, 10'h006, 6, 0, 0, 1, 0, 0, 10'h000, 0);
      vecs[6]  = mkv(1, 0, 10'h007, 7, 0, 0, 1, 0, 0, 10'h000, 0);
      vecs[7]  = mkv(1, 0, 10'h008, 8, 1, 0, 1, 0, 0, 10'h000, 0);
      vecs[8]  = mkv(1, 0, 10'h3FF, 8, 1, 0, 1, 0, 0, 10'h000, 1);
      vecs[9]  = mkv(0, 1, 10'h000, 7, 0, 0, 1, 0, 1, 10'h001, 1);
      vecs[10] = mkv(0, 1, 10'h000, 6, 0, 0, 1, 0, 1, 10'h002, 1);
      vecs[11] = mkv(0, 1, 10'h000, 5, 0, 0, 0, 0, 1, 10'h003, 1);
      vecs[12] = mkv(0, 1, 10'h000, 4, 0, 0, 0, 0, 1, 10'h004, 1);
      vecs[13] = mkv(0, 1, 10'h000, 3, 0, 0, 0, 0, 1, 10'h005, 1);
      vecs[14] = mkv(0, 1, 10'h000, 2, 0, 0, 0, 1, 1, 10'h006, 1);
      vecs[15] = mkv(0, 1, 10'h000, 1, 0, 0, 0, 1, 1, 10'h007, 1);
      vecs[16] = mkv(0, 1, 10'h000, 0, 0, 1, 0, 1, 1, 10'h008, 1);
      vecs[17] = mkv(0, 1, 10'h000, 0, 0, 1, 0, 1, 0, 10'h008, 1);

      // ---- Reset values, almost_full with zero threshold ----
      do_reset();
      #1;
      chk("rst_count", fifo_count, 0);
      chk("rst_empty", empty, 1);
      chk("rst_full", full, 0);
      chk("rst_almost_empty", almost_empty, 1);
      chk("rst_almost_full_th0", almost_full, 1);
      chk("rst_valid", valid_out, 0);
      chk("rst_dout", data_out, 0);
`ifdef FIFO_ERR_EN
      chk("rst_error", error_out, 0);
`endif
      th_almost_full = 4'd6;
      #1;
      chk("rst_almost_full_th6", almost_full, 0);

      // ---- Pop while empty ----
      cycle(1'b0, 1'b1, 10'h000);
      chk("udf_valid", valid_out, 0);
      chk("udf_dout", data_out, 0);
      chk("udf_count", fifo_count, 0);
`ifdef FIFO_ERR_EN
      chk("udf_error", error_out, 1);
      idle();
      chk("udf_error_sticky", error_out, 1);
`endif

      // ---- Table: fill, overflow, drain, underflow ----
      do_reset();
      for (int i = 0; i < 18; i++) begin
         cycle(vecs[i].push, vecs[i].pop, vecs[i].din);
         chk($sformatf("v%0d_count", i), fifo_count, vecs[i].cnt);
         chk($sformatf("v%0d_full", i), full, vecs[i].full);
         chk($sformatf("v%0d_empty", i), empty, vecs[i].empty);
         chk($sformatf("v%0d_almost_full", i), almost_full, vecs[i].af);
         chk($sformatf("v%0d_almost_empty", i), almost_empty, vecs[i].ae);
         chk($sformatf("v%0d_valid", i), valid_out, vecs[i].valid);
         chk($sformatf("v%0d_dout", i), data_out, vecs[i].dout);
`ifdef FIFO_ERR_EN
         chk($sformatf("v%0d_error", i), error_out, vecs[i].err);
`endif
      end

      // ---- Full FIFO with simultaneous push and pop ----
      do_reset();
      for (int i = 1; i <= 8; i++) begin
         cycle(1'b1, 1'b0, 10'(i));
      end
      chk("fpp_full_before", full, 1);
      cycle(1'b1, 1'b1, 10'h155);
      chk("fpp_count", fifo_count, 8);
      chk("fpp_valid", valid_out, 1);
      chk("fpp_dout", data_out, 1);
`ifdef FIFO_ERR_EN
      chk("fpp_no_error", error_out, 0);
`endif
      for (int i = 2; i <= 8; i++) begin
         cycle(1'b0, 1'b1, 10'h000);
         chk($sformatf("fpp_pop%0d", i), data_out, i);
      end
      cycle(1'b0, 1'b1, 10'h000);
      chk("fpp_last_valid", valid_out, 1);
      chk("fpp_last_dout", data_out, 10'h155);
      chk("fpp_empty", empty, 1);

      // ---- Mixed push/pop across pointer wrap, small queue model ----
      th_almost_empty = 4'd2;
      last_dout = 10'h155;
      for (int i = 0; i < 20; i++) begin
         wp = (i % 4) != 3;
         wq = (i >= 3) && ((i % 3) != 0);
         push_ok = wp && ((q_model.size() < 8) || wq);
         pop_ok  = wq && (q_model.size() > 0);
         if (pop_ok) last_dout = q_model.pop_front();
         if (push_ok) q_model.push_back(10'(10'h200 + i));
         cycle(wp, wq, 10'(10'h200 + i));
         chk($sformatf("wrap%0d_count", i), fifo_count, q_model.size());
         chk($sformatf("wrap%0d_almost_empty", i), almost_empty,
             (q_model.size() <= 2) ? 1 : 0);
         chk($sformatf("wrap%0d_valid", i), valid_out, pop_ok ? 1 : 0);
         chk($sformatf("wrap%0d_dout", i), data_out, last_dout);
      end

      // ---- Asynchronous reset mid-cycle with count = 5 ----
      do_reset();
      for (int i = 0; i < 5; i++) begin
         cycle(1'b1, 1'b0, 10'(10'h0A0 + i));
      end
      cycle(1'b1, 1'b1, 10'h0AA);
      chk("ar_count_before", fifo_count, 5);
      chk("ar_valid_before", valid_out, 1);
      chk("ar_dout_before", data_out, 10'h0A0);
      @(negedge clk);
      push = 1'b0;
      pop  = 1'b0;
      #2;
      reset_L = 1'b0;
      #1;
      chk("ar_count", fifo_count, 0);
      chk("ar_empty", empty, 1);
      chk("ar_full", full, 0);
      chk("ar_almost_empty", almost_empty, 1);
      chk("ar_almost_full", almost_full, 0);
      chk("ar_valid", valid_out, 0);
      chk("ar_dout", data_out, 0);
      @(negedge clk);
      reset_L = 1'b1;
      cycle(1'b0, 1'b1, 10'h000);
      chk("ar_pop_valid", valid_out, 0);
      chk("ar_pop_count", fifo_count, 0);
      chk("ar_pop_dout", data_out, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule : tb_fifo_sync_param

`default_nettype wire
